// File: rtl/a25_wishbone_pkg.sv
// Shared definitions for the Amber-style Wishbone port arbiter: state encoding,
// port indices and bus width defaults.
package a25_wishbone_pkg;

    localparam int DEF_WB_DWIDTH = 128;
    localparam int DEF_WB_SWIDTH = 16;
    localparam int DEF_N_PORTS   = 3;
    localparam int ADR_WIDTH     = 32;

    localparam logic [1:0] PORT_DUNCACHED = 2'd0;
    localparam logic [1:0] PORT_DCACHED   = 2'd1;
    localparam logic [1:0] PORT_ICACHE    = 2'd2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WB_WRITE = 2'd1,
        WB_READ  = 2'd2
    } wb_state_e;

    function automatic logic [2:0] port_onehot(input logic [1:0] idx);
        logic [2:0] oh;
        oh = 3'b000;
        case (idx)
            PORT_DUNCACHED: oh = 3'b001;
            PORT_DCACHED:   oh = 3'b010;
            PORT_ICACHE:    oh = 3'b100;
            default:        oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/a25_wishbone_prio_enc.sv
// Fixed-priority encoder over the three request lines; bit 0 wins.
// Produces the one-hot grant, its index and an any-request flag.
module a25_wishbone_prio_enc
    import a25_wishbone_pkg::*;
(
    input  logic [2:0] req,
    output logic [2:0] grant,
    output logic [1:0] idx,
    output logic       any
);

    // Lowest-numbered requester takes the grant.
    always_comb begin
        grant = 3'b000;
        idx   = PORT_DUNCACHED;
        any   = 1'b0;
        if (req[0]) begin
            grant = 3'b001;
            idx   = PORT_DUNCACHED;
            any   = 1'b1;
        end else if (req[1]) begin
            grant = 3'b010;
            idx   = PORT_DCACHED;
            any   = 1'b1;
        end else if (req[2]) begin
            grant = 3'b100;
            idx   = PORT_ICACHE;
            any   = 1'b1;
        end else begin
            grant = 3'b000;
            idx   = PORT_DUNCACHED;
            any   = 1'b0;
        end
    end

endmodule

// File: rtl/a25_wishbone_arb.sv
// Fixed-priority arbiter for the three core port buffers driving one Wishbone B3
// classic master; grants in IDLE, runs one bus cycle, returns read data to the granted port.
module a25_wishbone_arb
    import a25_wishbone_pkg::*;
#(
    parameter int WB_DWIDTH = DEF_WB_DWIDTH,
    parameter int WB_SWIDTH = DEF_WB_SWIDTH,
    parameter int N_PORTS   = DEF_N_PORTS
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [N_PORTS-1:0]             i_valid,
    input  logic [N_PORTS-1:0]             i_write,
    input  logic [N_PORTS*WB_DWIDTH-1:0]   i_wdata,
    input  logic [N_PORTS*WB_SWIDTH-1:0]   i_be,
    input  logic [N_PORTS*ADR_WIDTH-1:0]   i_addr,
    output logic [N_PORTS-1:0]             o_accepted,
    output logic [WB_DWIDTH-1:0]           o_rdata,
    output logic [N_PORTS-1:0]             o_rdata_valid,
    output logic [ADR_WIDTH-1:0]           o_wb_adr,
    output logic [WB_SWIDTH-1:0]           o_wb_sel,
    output logic                           o_wb_we,
    output logic [WB_DWIDTH-1:0]           o_wb_dat,
    output logic                           o_wb_cyc,
    output logic                           o_wb_stb,
    input  logic [WB_DWIDTH-1:0]           i_wb_dat,
    input  logic                           i_wb_ack,
    input  logic                           i_wb_err,
    output logic                           o_bus_err
);

    wb_state_e              state_r;
    wb_state_e              next_state_s;
    logic [2:0]             enc_grant_s;
    logic [1:0]             enc_idx_s;
    logic                   enc_any_s;
    logic [1:0]             grant_r;
    logic                   grant_s;
    logic                   done_s;
    logic [N_PORTS-1:0]     accepted_s;

    logic                   sel_write_s;
    logic [ADR_WIDTH-1:0]   sel_addr_s;
    logic [WB_DWIDTH-1:0]   sel_wdata_s;
    logic [WB_SWIDTH-1:0]   sel_be_s;

    logic [ADR_WIDTH-1:0]   wb_adr_r;
    logic [WB_SWIDTH-1:0]   wb_sel_r;
    logic                   wb_we_r;
    logic [WB_DWIDTH-1:0]   wb_dat_r;
    logic                   wb_cyc_r;
    logic                   wb_stb_r;
    logic [WB_DWIDTH-1:0]   rdata_r;
    logic [N_PORTS-1:0]     rdata_valid_r;
    logic                   bus_err_r;

    a25_wishbone_prio_enc u_prio_enc (
        .req   (i_valid),
        .grant (enc_grant_s),
        .idx   (enc_idx_s),
        .any   (enc_any_s)
    );

    // Route the winning port's request fields to the bus latch.
    always_comb begin
        sel_write_s = 1'b0;
        sel_addr_s  = {ADR_WIDTH{1'b0}};
        sel_wdata_s = {WB_DWIDTH{1'b0}};
        sel_be_s    = {WB_SWIDTH{1'b0}};
        case (enc_idx_s)
            PORT_DUNCACHED: begin
                sel_write_s = i_write[PORT_DUNCACHED];
                sel_addr_s  = i_addr[0 +: ADR_WIDTH];
                sel_wdata_s = i_wdata[0 +: WB_DWIDTH];
                sel_be_s    = i_be[0 +: WB_SWIDTH];
            end
            PORT_DCACHED: begin
                sel_write_s = i_write[PORT_DCACHED];
                sel_addr_s  = i_addr[ADR_WIDTH +: ADR_WIDTH];
                sel_wdata_s = i_wdata[WB_DWIDTH +: WB_DWIDTH];
                sel_be_s    = i_be[WB_SWIDTH +: WB_SWIDTH];
            end
            PORT_ICACHE: begin
                sel_write_s = i_write[PORT_ICACHE];
                sel_addr_s  = i_addr[2*ADR_WIDTH +: ADR_WIDTH];
                sel_wdata_s = i_wdata[2*WB_DWIDTH +: WB_DWIDTH];
                sel_be_s    = i_be[2*WB_SWIDTH +: WB_SWIDTH];
            end
            default: sel_write_s = 1'b0;
        endcase
    end

    // Next-state logic; the grant pulse is combinational so buffers can pop this cycle.
    always_comb begin
        next_state_s = state_r;
        accepted_s   = {N_PORTS{1'b0}};
        grant_s      = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (enc_any_s) begin
                    grant_s      = 1'b1;
                    accepted_s   = enc_grant_s;
                    next_state_s = sel_write_s ? WB_WRITE : WB_READ;
                end else begin
                    next_state_s = IDLE;
                end
            end
            WB_WRITE, WB_READ: begin
                if (i_wb_ack || i_wb_err) begin
                    done_s       = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Bus-side registers: latched at grant, held until ack/err ends the cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wb_adr_r <= {ADR_WIDTH{1'b0}};
            wb_sel_r <= {WB_SWIDTH{1'b0}};
            wb_we_r  <= 1'b0;
            wb_dat_r <= {WB_DWIDTH{1'b0}};
            wb_cyc_r <= 1'b0;
            wb_stb_r <= 1'b0;
            grant_r  <= PORT_DUNCACHED;
        end else if (grant_s) begin
            wb_adr_r <= sel_addr_s;
            wb_sel_r <= sel_be_s;
            wb_we_r  <= sel_write_s;
            wb_dat_r <= sel_wdata_s;
            wb_cyc_r <= 1'b1;
            wb_stb_r <= 1'b1;
            grant_r  <= enc_idx_s;
        end else if (done_s) begin
            wb_cyc_r <= 1'b0;
            wb_stb_r <= 1'b0;
        end
    end

    // Port-side response: read data with a one-cycle valid, and the sticky error flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdata_r       <= {WB_DWIDTH{1'b0}};
            rdata_valid_r <= {N_PORTS{1'b0}};
            bus_err_r     <= 1'b0;
        end else begin
            rdata_valid_r <= {N_PORTS{1'b0}};
            if (done_s && (state_r == WB_READ)) begin
                rdata_r       <= i_wb_dat;
                rdata_valid_r <= port_onehot(grant_r);
            end
            if (done_s && i_wb_err) begin
                bus_err_r <= 1'b1;
            end
        end
    end

    assign o_accepted    = accepted_s;
    assign o_rdata       = rdata_r;
    assign o_rdata_valid = rdata_valid_r;
    assign o_wb_adr      = wb_adr_r;
    assign o_wb_sel      = wb_sel_r;
    assign o_wb_we       = wb_we_r;
    assign o_wb_dat      = wb_dat_r;
    assign o_wb_cyc      = wb_cyc_r;
    assign o_wb_stb      = wb_stb_r;
    assign o_bus_err     = bus_err_r;

endmodule
